mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide/modulo unit with its own sequencer. It sits beside the single-cycle ALU in the execute stage.
- When the decoded ALU signal is MUL, DIV or MOD, it stalls the pipeline and iterates one bit per cycle.
- It returns a 32-bit result with a single-cycle done pulse, during which the pipeline releases and captures the result.
- It supports flush, for branch/ret redirects from older instructions.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/mdu_iter_core.sv | 72 +++++++
 rtl/mdu_sequencer.sv | 135 +++++++++++++
 tb/tb_mdu_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU signal codes used by the control decoder and
// execute stage, plus the multiply/divide sequencer state encoding.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b00010;
    localparam logic [4:0] ALU_DIV = 5'b00011;
    localparam logic [4:0] ALU_MOD = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;
    localparam logic [4:0] ALU_XOR = 5'b00111;
    localparam logic [4:0] ALU_SLL = 5'b01000;
    localparam logic [4:0] ALU_SRL = 5'b01001;
    localparam logic [4:0] ALU_ASR = 5'b01010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// Bit-serial datapath shared by multiply (shift-add) and divide (restoring,
// non-performing). Works on unsigned magnitudes; signs are handled outside.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // acc_reg: product accumulator or partial remainder.
    // sh_a_reg: shifting multiplicand, or dividend shifting out / quotient shifting in.
    // sh_b_reg: multiplier shifting right, or the fixed divisor.
    logic [WIDTH:0]   acc_reg;
    logic [WIDTH-1:0] sh_a_reg;
    logic [WIDTH-1:0] sh_b_reg;

    logic [WIDTH:0]   lhs;
    logic [WIDTH:0]   addend;
    logic             cin;
    logic [WIDTH+1:0] sum;

    // One adder: acc + multiplicand, or trial subtract (carry out = no borrow).
    always_comb begin
        if (is_mul) begin
            lhs    = acc_reg;
            addend = sh_b_reg[0] ? {1'b0, sh_a_reg} : '0;
            cin    = 1'b0;
        end else begin
            lhs    = {acc_reg[WIDTH-1:0], sh_a_reg[WIDTH-1]};
            addend = ~{1'b0, sh_b_reg};
            cin    = 1'b1;
        end
        sum = {1'b0, lhs} + {1'b0, addend} + {{(WIDTH+1){1'b0}}, cin};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg  <= '0;
            sh_a_reg <= '0;
            sh_b_reg <= '0;
        end else if (load) begin
            acc_reg  <= '0;
            sh_a_reg <= mag_a;
            sh_b_reg <= mag_b;
        end else if (step) begin
            if (is_mul) begin
                acc_reg  <= sum[WIDTH:0];
                sh_a_reg <= sh_a_reg << 1;
                sh_b_reg <= sh_b_reg >> 1;
            end else if (sum[WIDTH+1]) begin
                acc_reg  <= sum[WIDTH:0];
                sh_a_reg <= {sh_a_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_reg  <= lhs;
                sh_a_reg <= {sh_a_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign product   = acc_reg[WIDTH-1:0];
    assign quotient  = sh_a_reg;
    assign remainder = acc_reg[WIDTH-1:0];

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIV/MOD unit for the execute stage: stalls the pipeline,
// iterates one bit per cycle and returns the result with a one-cycle done pulse.
module mdu_sequencer
    import cpu_pkg::*;
#(
    parameter int         WIDTH  = XLEN,
    parameter logic [4:0] MUL_OP = ALU_MUL,
    parameter logic [4:0] DIV_OP = ALU_DIV,
    parameter logic [4:0] MOD_OP = ALU_MOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alu_signal,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t       state_reg;
    logic [CW-1:0]    count_reg;
    logic [4:0]       op_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic             dz_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_reg;
    logic             dbz_reg;

    logic             is_md;
    logic             accept;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] fix_value;

    assign is_md  = (alu_signal == MUL_OP) || (alu_signal == DIV_OP) || (alu_signal == MOD_OP);
    assign accept = (state_reg == IDLE) && start && is_md && !flush;
    assign mag_a  = op_a[WIDTH-1] ? -op_a : op_a;
    assign mag_b  = op_b[WIDTH-1] ? -op_b : op_b;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .step      (state_reg == CALC),
        .is_mul    (op_reg == MUL_OP),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // On divide-by-zero the core still holds |op_a| in its dividend register.
    always_comb begin
        fix_value = '0;
        if (op_reg == MUL_OP) begin
            fix_value = (sign_a_reg ^ sign_b_reg) ? -product : product;
        end else if (op_reg == DIV_OP) begin
            fix_value = dz_reg ? '1 : ((sign_a_reg ^ sign_b_reg) ? -quotient : quotient);
        end else if (dz_reg) begin
            fix_value = sign_a_reg ? -quotient : quotient;
        end else begin
            fix_value = sign_a_reg ? -remainder : remainder;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            dz_reg     <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
            dbz_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg     <= alu_signal;
                        sign_a_reg <= op_a[WIDTH-1];
                        sign_b_reg <= op_b[WIDTH-1];
                        dz_reg     <= (alu_signal != MUL_OP) && (op_b == '0);
                        count_reg  <= CW'(WIDTH - 1);
                        state_reg  <= ((alu_signal != MUL_OP) && (op_b == '0)) ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                        if (count_reg == '0) begin
                            state_reg <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        result_reg <= fix_value;
                        dbz_reg    <= dz_reg;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Flush drops the stall in the same cycle so the redirect can proceed.
    assign stall       = !reset && (accept || (((state_reg == CALC) || (state_reg == FIX)) && !flush));
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign result      = result_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases plus randomized
// operations checked against a signed-arithmetic reference model.
module tb_mdu_sequencer;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  alu_signal;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_result = 32'h0;

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_signal  (alu_signal),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    function automatic logic [31:0] ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MUL) r = sa * sb;
        else if (b == 32'h0) r = (op == OP_DIV) ? -1 : sa;
        else if (op == OP_DIV) r = sa / sb;
        else r = sa % sb;
        return r[31:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20) - 10;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after done.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input string name);
        int n;
        int lat_exp;
        logic exp_dz;
        logic stall_bad;
        exp_dz  = (op != OP_MUL) && (b == 32'h0);
        lat_exp = exp_dz ? 2 : 34;
        start = 1'b1; alu_signal = op; op_a = a; op_b = b;
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL %s accept_stall: got %b expected 1", name, stall); end
        @(posedge clk); @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom; alu_signal = 5'($urandom);
        n = 1; stall_bad = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            if (stall !== 1'b1 || busy !== 1'b1) stall_bad = 1'b1;
            @(negedge clk); n++;
        end
        checks++;
        if (n != lat_exp) begin failures++; $display("FAIL %s latency: got %0d expected %0d", name, n, lat_exp); end
        checks++;
        if (stall_bad) begin failures++; $display("FAIL %s stall_busy_during_op: got drop expected held 1", name); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL %s stall_at_done: got %b expected 0", name, stall); end
        checks++;
        if (result !== exp_res) begin failures++; $display("FAIL %s result: got %h expected %h", name, result, exp_res); end
        checks++;
        if (div_by_zero !== exp_dz) begin failures++; $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, exp_dz); end
        $display("op %s alu=%0d a=%h b=%h result=%h dbz=%b latency=%0d", name, op, a, b, result, div_by_zero, n);
        last_result = exp_res;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL %s done_pulse: got done=%b busy=%b expected 0 0", name, done, busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; alu_signal = OP_ADD; op_a = '0; op_b = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall, busy, done, div_by_zero} !== 4'b0 || result !== 32'h0) begin
            failures++; $display("FAIL reset_outputs: got stall=%b busy=%b done=%b dbz=%b result=%h expected all 0",
                                 stall, busy, done, div_by_zero, result);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_directed();
        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_-7/2");
        run_op(OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "mod_-7%2");
        run_op(OP_MOD, 32'd7, 32'hFFFF_FFFE, 32'd1, "mod_7%-2");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_min/-1");
        run_op(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "mod_min/-1");
        run_op(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_5/0");
        run_op(OP_MOD, 32'd5, 32'd0, 32'd5, "mod_5/0");
        run_op(OP_MOD, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "mod_-7/0");
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: op = OP_MUL;
                1: op = OP_DIV;
                default: op = OP_MOD;
            endcase
            a = pick_operand();
            b = pick_operand();
            run_op(op, a, b, ref_md(op, a, b), "random");
        end
    endtask

    task automatic test_non_md();
        bit bad;
        start = 1'b1; alu_signal = OP_ADD; op_a = 32'd9; op_b = 32'd4;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (bad) begin failures++; $display("FAIL non_md_start: got stall/busy/done activity expected none"); end
        $display("op add ignored stall=%b busy=%b", stall, busy);
    endtask

    task automatic test_flush();
        bit bad;
        // flush together with start in IDLE
        start = 1'b1; alu_signal = OP_MUL; op_a = 32'd6; op_b = 32'd6; flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL flush_start_stall: got %b expected 0", stall); end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
        $display("op mul with same-cycle flush not accepted busy=%b", busy);
        // flush mid-CALC
        start = 1'b1; alu_signal = OP_MUL; op_a = $urandom; op_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL flush_cycle_stall: got %b expected 0", stall); end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL flush_idle: got busy=%b stall=%b expected 0 0", busy, stall); end
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin failures++; $display("FAIL flush_no_done: got done pulse expected none"); end
        checks++;
        if (result !== last_result) begin failures++; $display("FAIL flush_result_kept: got %h expected %h", result, last_result); end
        $display("op mul flushed at T+10 result=%h", result);
        run_op(OP_DIV, 32'd100, 32'd7, 32'd14, "div_100/7_after_flush");
    endtask

    task automatic test_start_in_calc();
        int n;
        start = 1'b1; alu_signal = OP_MUL; op_a = 32'd1234; op_b = 32'hFFFF_FF00;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            if (n == 5) begin start = 1'b1; alu_signal = OP_DIV; op_a = 32'd77; op_b = 32'd3; end
            else start = 1'b0;
            @(negedge clk); n++;
        end
        start = 1'b0;
        checks++;
        if (n != 34) begin failures++; $display("FAIL start_in_calc_latency: got %0d expected 34", n); end
        checks++;
        if (result !== ref_md(OP_MUL, 32'd1234, 32'hFFFF_FF00)) begin
            failures++; $display("FAIL start_in_calc_result: got %h expected %h", result, ref_md(OP_MUL, 32'd1234, 32'hFFFF_FF00));
        end
        $display("op mul with start during CALC result=%h", result);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL start_in_calc_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        start = 1'b1; alu_signal = OP_DIV; op_a = 32'd1000; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({stall, busy, done, div_by_zero} !== 4'b0 || result !== 32'h0) begin
            failures++; $display("FAIL async_reset_outputs: got stall=%b busy=%b done=%b dbz=%b result=%h expected all 0",
                                 stall, busy, done, div_by_zero, result);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_reset_idle: got busy=%b done=%b expected 0 0", busy, done); end
        $display("async reset mid-CALC outputs cleared");
        run_op(OP_MUL, 32'd3, 32'd4, 32'd12, "mul_3x4_after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_non_md();
        test_flush();
        test_start_in_calc();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
